ahb_spi_master: RTL and testbench
=================================

// Module: ahb_spi_master
// PURPOSE
//  AHB-Lite slave on the HSEL_spi decoder slot that drives the Nexys4Display serial input.
//  A CPU write to TXDATA starts one MSB-first frame on SCLK/SS/MOSI; MISO is shifted into RXDATA.
//  A sticky done flag, which is also the level IRQ, tells firmware when the display frame is complete.
// PARAMETERS
//  DATA_W   16  frame length in bits (1..32); uses HWDATA[DATA_W-1:0]
//  CLK_DIV  8   HCLK cycles per SCLK half-period (>=2); default gives 3.125 MHz, below the 6.25 MHz display clock
// PORTS
//  HCLK        in   1   bus clock, 50 MHz; the only clock
//  HRESETn     in   1   reset, synchronous, active-low
//  HSEL        in   1   slave select from AHBDCD
//  HREADY      in   1   bus ready (previous transfer completing)
//  HADDR       in   32  address; only [3:2] decoded
//  HTRANS      in   2   transfer type; only [1] used
//  HWRITE      in   1   write transfer
//  HSIZE       in   3   transfer size; ignored, full-word semantics
//  HWDATA      in   32  write data (data phase)
//  HRDATA      out  32  read data
//  HREADYOUT   out  1   tied 1 (zero wait states)
//  spi_miso_i  in   1   serial data in
//  spi_sclk_o  out  1   serial clock: idle high, receiver samples on rising edge
//  spi_ss_o    out  1   slave select, active low, idle high
//  spi_mosi_o  out  1   serial data out, idle high
//  spi_irq_o   out  1   equals STATUS.done
// BEHAVIOUR
//  Reset (HRESETn=0 at a HCLK edge): next edge gives sclk=1, ss=1, mosi=1, state IDLE.
//   TXDATA, RXDATA, busy, done, ovr and irq all return to 0. This also applies mid-frame:
//   the frame is abandoned with no trailing edge.
//  AHB: address phase is latched when HSEL & HREADY & HTRANS[1]. Capture HADDR[3:2] and HWRITE.
//   The register action happens in the following (data-phase) cycle using HWDATA.
//   HRDATA is combinational from the latched address. Unmapped offsets read 0; writes to them are ignored.
//  Map (word offsets):
//   0x0 TXDATA  R/W  last written word
//   0x4 STATUS  R {29'b0,ovr,done,busy}; W1C on bits [2:1]
//   0x8 RXDATA  R    word shifted in from MISO
//  TXDATA write while busy=0: load shifter, set busy, clear done, and go to LEAD on the next edge.
//  TXDATA write while busy=1: TXDATA register updates, the frame is untouched, ovr set.
//  FSM IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE. The CLK_DIV counter times every phase.
//   LEAD:  ss=0, sclk=1, mosi=data[DATA_W-1], for CLK_DIV cycles.
//   SHIFT: for each bit, sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
//    mosi changes only at sclk falling edges (bit k is presented at fall k).
//    MISO is sampled into rx LSB at each sclk rising edge.
//   TRAIL: sclk=1, ss=0 for CLK_DIV cycles, then ss=1 and mosi=1.
//    On the same edge: busy=0, done=1, RXDATA updated.
//  Frame length from busy rise to busy fall = CLK_DIV*(2*DATA_W+2) cycles (272 at defaults).
//  Simultaneous events:
//   - Hardware done-set and a W1C clear in the same cycle: set wins.
//   - TXDATA write in the cycle busy falls: busy is still 1, so ovr is set and no new frame starts.
//   - Outputs are registered, so there are no glitches on sclk/ss/mosi.
// STRUCTURE
//  Include file ahb_spi_defs.vh holds the register offsets (TX=2'd0, ST=2'd1, RX=2'd2),
//   the STATUS bit indices, and the FSM state encodings.
//  Sub-module spi_shift_engine (DATA_W, CLK_DIV) holds the FSM, divider, and TX/RX shifters.
//   Its handshake is start/busy/done_pulse.
//  The top module holds the AHB interface, registers, and IRQ.
// TESTING
//  1 Reset: hold HRESETn=0 for 5 cycles -> sclk=ss=mosi=1, HRDATA of STATUS=0, irq=0.
//  2 Write TXDATA=0xA5C3 -> ss falls 1 cycle later, 16 sclk rising edges, mosi bits 1010_0101_1100_0011.
//    Check busy for 272 cycles, then done=1 and irq=1.
//  3 MISO driven from pattern 0x3C5A, sampled at rising edges -> RXDATA=0x00003C5A.
//    Write STATUS=0x6 -> done=0, irq=0.
//  4 Second TXDATA write 20 cycles into a frame -> ovr=1, frame bits unchanged, TXDATA reads back the new value.
//  5 Assert HRESETn=0 mid-SHIFT (bit 7) -> next edge ss=1, sclk=1, busy=0, done=0.
//    No further sclk edges occur.
//  6 Write in the exact cycle busy falls, and a STATUS W1C coincident with done-set.
//    Expect ovr=1 with no new frame, and done=1.

Source files
------------

// File: rtl/ahb_spi_master_pkg.sv
// Shared register map, STATUS bit positions and shift-engine state encoding
// for the AHB-Lite SPI master.
package ahb_spi_master_pkg;

   localparam logic [1:0] OFF_TX = 2'd0;
   localparam logic [1:0] OFF_ST = 2'd1;
   localparam logic [1:0] OFF_RX = 2'd2;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_OVR  = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LEAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_TRAIL = 2'd3
   } spi_state_e;

   // Data-phase context captured from the AHB address phase
   typedef struct packed {
      logic       valid;
      logic       write;
      logic [1:0] addr;
   } ahb_dp_t;

endpackage

// File: rtl/spi_shift_engine.sv
// One MSB-first SPI frame per start pulse: LEAD, DATA_W clocked bits, TRAIL.
// All serial outputs are registered; every phase lasts CLK_DIV cycles.
module spi_shift_engine
   import ahb_spi_master_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
   output logic              sclk,
   output logic              ss,
   output logic              mosi,
   output logic              busy,
   output logic              done_pulse,
   output logic [DATA_W-1:0] rx_data
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic              sclk_q, sclk_d;
   logic              ss_q, ss_d;
   logic              mosi_q, mosi_d;
   logic              tick;

   assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         sclk_q  <= 1'b1;
         ss_q    <= 1'b1;
         mosi_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         sclk_q  <= sclk_d;
         ss_q    <= ss_d;
         mosi_q  <= mosi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      sclk_d  = sclk_q;
      ss_d    = ss_q;
      mosi_d  = mosi_q;
      if (state_q != S_IDLE)
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      unique case (state_q)
         S_IDLE: if (start) begin
            state_d = S_LEAD;
            cnt_d   = '0;
            bit_d   = '0;
            tx_d    = tx_data;
            rx_d    = '0;
            ss_d    = 1'b0;
            sclk_d  = 1'b1;
            mosi_d  = tx_data[DATA_W-1];
         end
         S_LEAD: if (tick) begin
            state_d = S_SHIFT;
            sclk_d  = 1'b0;
            mosi_d  = tx_q[DATA_W-1];
            tx_d    = tx_q << 1;
         end
         // Low half ends with a rising edge (sample MISO); high half ends with
         // the next falling edge (present next bit) or the move to TRAIL.
         S_SHIFT: if (tick) begin
            if (!sclk_q) begin
               sclk_d = 1'b1;
               rx_d   = (rx_q << 1) | DATA_W'(miso);
            end else if (bit_q == BIT_W'(DATA_W - 1)) begin
               state_d = S_TRAIL;
            end else begin
               bit_d  = bit_q + 1'b1;
               sclk_d = 1'b0;
               mosi_d = tx_q[DATA_W-1];
               tx_d   = tx_q << 1;
            end
         end
         S_TRAIL: if (tick) begin
            state_d = S_IDLE;
            ss_d    = 1'b1;
            mosi_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sclk       = sclk_q;
   assign ss         = ss_q;
   assign mosi       = mosi_q;
   assign busy       = (state_q != S_IDLE);
   assign done_pulse = (state_q == S_TRAIL) && tick;
   assign rx_data    = rx_q;

endmodule

// File: rtl/ahb_spi_master.sv
// AHB-Lite slave wrapping the SPI shift engine: TXDATA/STATUS/RXDATA registers,
// sticky done/overrun flags and a level IRQ mirroring done.
module ahb_spi_master
   import ahb_spi_master_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 8
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   input  logic        spi_miso_i,
   output logic        spi_sclk_o,
   output logic        spi_ss_o,
   output logic        spi_mosi_o,
   output logic        spi_irq_o
);

   ahb_dp_t           dp_q;
   logic [31:0]       tx_reg;
   logic [DATA_W-1:0] rx_reg;
   logic              done_q, ovr_q;
   logic              busy, done_pulse, start, tx_wr, st_wr;
   logic [DATA_W-1:0] rx_data;
   logic              unused_ok;

   assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};

   always_ff @(posedge HCLK) begin
      if (!HRESETn)
         dp_q <= '0;
      else if (HREADY) begin
         dp_q.valid <= HSEL & HTRANS[1];
         dp_q.write <= HWRITE;
         dp_q.addr  <= HADDR[3:2];
      end
   end

   assign tx_wr = dp_q.valid & dp_q.write & (dp_q.addr == OFF_TX);
   assign st_wr = dp_q.valid & dp_q.write & (dp_q.addr == OFF_ST);
   // A write that lands while busy (including the busy-fall cycle) only updates TXDATA
   assign start = tx_wr & ~busy;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         tx_reg <= '0;
         rx_reg <= '0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (tx_wr)      tx_reg <= HWDATA;
         if (done_pulse) rx_reg <= rx_data;
         if (done_pulse)
            done_q <= 1'b1;
         else if (start || (st_wr && HWDATA[ST_DONE]))
            done_q <= 1'b0;
         if (tx_wr && busy)
            ovr_q <= 1'b1;
         else if (st_wr && HWDATA[ST_OVR])
            ovr_q <= 1'b0;
      end
   end

   always_comb begin
      HRDATA = '0;
      unique case (dp_q.addr)
         OFF_TX:  HRDATA = tx_reg;
         OFF_ST:  HRDATA = 32'({ovr_q, done_q, busy});
         OFF_RX:  HRDATA = 32'(rx_reg);
         default: HRDATA = '0;
      endcase
   end

   assign HREADYOUT = 1'b1;
   assign spi_irq_o = done_q;

   spi_shift_engine #(
      .DATA_W (DATA_W),
      .CLK_DIV(CLK_DIV)
   ) u_engine (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .start     (start),
      .tx_data   (HWDATA[DATA_W-1:0]),
      .miso      (spi_miso_i),
      .sclk      (spi_sclk_o),
      .ss        (spi_ss_o),
      .mosi      (spi_mosi_o),
      .busy      (busy),
      .done_pulse(done_pulse),
      .rx_data   (rx_data)
   );

endmodule

// File: tb/tb_ahb_spi_master.sv
// Directed bench for ahb_spi_master at DATA_W=16, CLK_DIV=8 (272-cycle frames).
module tb_ahb_spi_master;

   localparam logic [31:0] A_TX = 32'h0;
   localparam logic [31:0] A_ST = 32'h4;
   localparam logic [31:0] A_RX = 32'h8;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL, HREADY, HWRITE;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HREADYOUT;
   logic        spi_miso_i, spi_sclk_o, spi_ss_o, spi_mosi_o, spi_irq_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_rises  = 0;
   int          n_falls  = 0;
   logic [31:0] mon_bits = '0;
   logic [15:0] miso_pat = '0;

   always #10 HCLK = ~HCLK;

   ahb_spi_master #(.DATA_W(16), .CLK_DIV(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
      .spi_miso_i(spi_miso_i), .spi_sclk_o(spi_sclk_o), .spi_ss_o(spi_ss_o),
      .spi_mosi_o(spi_mosi_o), .spi_irq_o(spi_irq_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Slave-side model of the display: captures MOSI at sclk rises, drives MISO after falls
   initial begin
      logic prev_sclk;
      int   fidx;
      prev_sclk  = 1'b1;
      fidx       = 0;
      spi_miso_i = 1'b0;
      forever begin
         @(negedge HCLK);
         if (spi_ss_o) fidx = 0;
         if (prev_sclk && !spi_sclk_o && !spi_ss_o) begin
            if (fidx < 16) spi_miso_i = miso_pat[15-fidx];
            fidx++;
            n_falls++;
         end
         if (!prev_sclk && spi_sclk_o && !spi_ss_o) begin
            mon_bits = {mon_bits[30:0], spi_mosi_o};
            n_rises++;
         end
         prev_sclk = spi_sclk_o;
      end
   end

   task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
   endtask

   task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      data = HRDATA;
   endtask

   task automatic wait_ss_high(output int n);
      n = 0;
      while (spi_ss_o === 1'b0 && n < 2000) begin
         @(negedge HCLK);
         n++;
      end
      if (n >= 2000) check("ss_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          n, r0;
      HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = '0;
      HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = '0;

      // 1: reset
      repeat (5) @(negedge HCLK);
      check("rst_sclk", 32'(spi_sclk_o), 32'd1);
      check("rst_ss",   32'(spi_ss_o),   32'd1);
      check("rst_mosi", 32'(spi_mosi_o), 32'd1);
      check("rst_irq",  32'(spi_irq_o),  32'd0);
      HRESETn = 1'b1;
      ahb_read(A_ST, rd); check("rst_status", rd, 32'h0);
      ahb_read(A_TX, rd); check("rst_tx", rd, 32'h0);
      ahb_read(A_RX, rd); check("rst_rx", rd, 32'h0);
      ahb_read(32'hC, rd); check("unmapped_rd", rd, 32'h0);

      // 2: frame 0xA5C3, MISO answers 0x3C5A
      miso_pat = 16'h3C5A;
      r0 = n_rises;
      ahb_write(A_TX, 32'h0000_A5C3);
      check("ss_pre", 32'(spi_ss_o), 32'd1);
      @(negedge HCLK);
      check("ss_fall", 32'(spi_ss_o), 32'd0);
      wait_ss_high(n);
      check("frame_len", 32'(n), 32'd272);
      check("rises", 32'(n_rises - r0), 32'd16);
      check("mosi_bits", {16'h0, mon_bits[15:0]}, 32'h0000_A5C3);
      check("idle_mosi", 32'(spi_mosi_o), 32'd1);
      ahb_read(A_ST, rd); check("status_done", rd, 32'h2);
      check("irq_set", 32'(spi_irq_o), 32'd1);

      // 3: RX and W1C
      ahb_read(A_RX, rd); check("rxdata", rd, 32'h0000_3C5A);
      ahb_write(A_ST, 32'h6);
      ahb_read(A_ST, rd); check("w1c_status", rd, 32'h0);
      check("irq_clr", 32'(spi_irq_o), 32'd0);

      // 4: overrun write mid-frame
      miso_pat = 16'h0;
      r0 = n_rises;
      ahb_write(A_TX, 32'h0000_1234);
      repeat (18) @(negedge HCLK);
      ahb_write(A_TX, 32'h0000_BEEF);
      ahb_read(A_ST, rd); check("ovr_busy", rd, 32'h5);
      wait_ss_high(n);
      check("ovr_rises", 32'(n_rises - r0), 32'd16);
      check("ovr_bits", {16'h0, mon_bits[15:0]}, 32'h0000_1234);
      ahb_read(A_TX, rd); check("tx_readback", rd, 32'h0000_BEEF);
      ahb_read(A_ST, rd); check("ovr_done", rd, 32'h6);
      ahb_write(A_ST, 32'h6);
      ahb_read(A_ST, rd); check("ovr_clr", rd, 32'h0);

      // 5: reset during bit 7
      n = n_falls;
      ahb_write(A_TX, 32'h0000_FFFF);
      r0 = 0;
      while (n_falls - n < 8 && r0 < 1000) begin @(negedge HCLK); r0++; end
      check("bit7_reached", 32'(n_falls - n), 32'd8);
      HRESETn = 1'b0;
      @(negedge HCLK);
      check("midrst_ss",   32'(spi_ss_o),   32'd1);
      check("midrst_sclk", 32'(spi_sclk_o), 32'd1);
      check("midrst_mosi", 32'(spi_mosi_o), 32'd1);
      @(negedge HCLK);
      HRESETn = 1'b1;
      ahb_read(A_ST, rd); check("midrst_status", rd, 32'h0);
      r0 = n_rises;
      repeat (300) @(negedge HCLK);
      check("no_more_edges", 32'(n_rises - r0), 32'd0);
      check("still_ss", 32'(spi_ss_o), 32'd1);

      // 6a: TXDATA write in the busy-fall cycle
      ahb_write(A_TX, 32'h0000_00FF);
      repeat (270) @(negedge HCLK);
      ahb_write(A_TX, 32'h0000_5555);
      @(negedge HCLK);
      check("fall_ss", 32'(spi_ss_o), 32'd1);
      repeat (10) @(negedge HCLK);
      check("no_new_frame", 32'(spi_ss_o), 32'd1);
      ahb_read(A_ST, rd); check("fall_status", rd, 32'h6);
      ahb_read(A_TX, rd); check("fall_tx", rd, 32'h0000_5555);
      ahb_write(A_ST, 32'h6);
      ahb_read(A_ST, rd); check("fall_clr", rd, 32'h0);

      // 6b: W1C coincident with hardware done-set
      ahb_write(A_TX, 32'h0000_0F0F);
      repeat (270) @(negedge HCLK);
      ahb_write(A_ST, 32'h6);
      @(negedge HCLK);
      ahb_read(A_ST, rd); check("set_wins", rd, 32'h2);
      check("set_wins_irq", 32'(spi_irq_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
